// File: rtl/ccr_pkg.sv
// ----------------------------------------------------------------------------
// ccr_pkg
//   Shared definitions for the condition-code register block.
//   - Flag bit positions for the architectural flags (Z, N, C, V).
//   - Default flag count and save/restore depth.
//   - ccr_merge(): the live-update equation applied to the CCR each cycle.
//     It works on a fixed-width word so any NFLAGS up to CCR_MAXW can use it;
//     callers widen the operands and truncate the result back to NFLAGS.
// ----------------------------------------------------------------------------
package ccr_pkg;

   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   localparam int NFLAGS_DEF = 4;
   localparam int DEPTH_DEF  = 2;

   localparam int CCR_MAXW = 32;

   typedef logic [CCR_MAXW-1:0] ccr_word_t;

   // Priority within one cycle: clear beats set, set beats the ALU write.
   function automatic ccr_word_t ccr_merge(
      input ccr_word_t cur,
      input ccr_word_t we,
      input ccr_word_t din,
      input ccr_word_t set,
      input ccr_word_t clr
   );
      ccr_word_t u;
      ccr_word_t s;
      u = (cur & ~we) | (din & we);
      s = u | set;
      return s & ~clr;
   endfunction

endpackage

// File: rtl/ccr_ctx_if.sv
// ----------------------------------------------------------------------------
// ccr_ctx_if
//   Bundles the flag-update controls and status of the condition-code register.
//   master : driver side (execute stage / interrupt controller)
//            drives flag_in, flag_we, set_mask, clr_mask, save, restore, err_clr
//            observes ccr_out, depth, stack_full, stack_empty, ovf_err, unf_err
//   slave  : the ccr_ctx block, opposite directions
//   NFLAGS and DEPTH must match the parameters of the attached ccr_ctx.
// ----------------------------------------------------------------------------
interface ccr_ctx_if #(
   parameter int NFLAGS = 4,
   parameter int DEPTH  = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NFLAGS-1:0] flag_in;
   logic [NFLAGS-1:0] flag_we;
   logic [NFLAGS-1:0] set_mask;
   logic [NFLAGS-1:0] clr_mask;
   logic              save;
   logic              restore;
   logic              err_clr;
   logic [NFLAGS-1:0] ccr_out;
   logic [CW-1:0]     depth;
   logic              stack_full;
   logic              stack_empty;
   logic              ovf_err;
   logic              unf_err;

   modport master (
      output flag_in, flag_we, set_mask, clr_mask, save, restore, err_clr,
      input  ccr_out, depth, stack_full, stack_empty, ovf_err, unf_err
   );

   modport slave (
      input  flag_in, flag_we, set_mask, clr_mask, save, restore, err_clr,
      output ccr_out, depth, stack_full, stack_empty, ovf_err, unf_err
   );
endinterface

// File: rtl/ccr_lifo.sv
// ----------------------------------------------------------------------------
// ccr_lifo
//   Save/restore stack for CCR snapshots.
//   Ports:
//     clk, rst   clock and synchronous active-high reset (empties the stack)
//     push, din  store din on top; ignored when full
//     pop        discard top entry; ignored when empty; wins over push
//     dout       current top entry (contents undefined when empty)
//     cnt        number of valid entries (0..DEPTH)
//     full/empty decoded from cnt
//   No error reporting here; the enclosing block decides what is an error.
// ----------------------------------------------------------------------------
module ccr_lifo #(
   parameter  int W     = 4,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] cnt,
   output logic          full,
   output logic          empty
);

   // Storage is sized to the full index range of cnt so that every index
   // value (including the wrapped cnt-1 when empty) addresses a real entry.
   localparam int NSLOT = 1 << CW;

   logic [W-1:0]  mem_q [0:NSLOT-1];
   logic [W-1:0]  mem_d [0:NSLOT-1];
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] top_idx_s;
   logic          full_s;
   logic          empty_s;

   assign full_s    = (cnt_q == CW'(DEPTH));
   assign empty_s   = (cnt_q == {CW{1'b0}});
   assign top_idx_s = cnt_q - CW'(1);

   assign dout  = mem_q[top_idx_s];
   assign cnt   = cnt_q;
   assign full  = full_s;
   assign empty = empty_s;

   // Next-state for stack contents and entry count.
   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      if (pop && !empty_s) begin
         cnt_d = cnt_q - CW'(1);
      end else if (push && !full_s) begin
         mem_d[cnt_q] = din;
         cnt_d        = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stack storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Entry count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ccr_ctx.sv
// ----------------------------------------------------------------------------
// ccr_ctx
//   Condition-code register with per-flag write enables, explicit set/clear
//   masks and a save/restore stack for interrupt context.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   ccr_ctx_if.slave:
//             flag_in/flag_we   ALU flag values and per-flag enables
//             set_mask/clr_mask force flags to 1 / 0 (clear has priority)
//             save/restore      push current CCR / pop into CCR (restore wins)
//             err_clr           clear sticky errors (new error event wins)
//             ccr_out           registered flags
//             depth             valid stack entries
//             stack_full/empty  decoded from depth
//             ovf_err/unf_err   sticky push-while-full / pop-while-empty
//   Every output is a register or a decode of a register.
// ----------------------------------------------------------------------------
module ccr_ctx
   import ccr_pkg::*;
#(
   parameter  int NFLAGS = NFLAGS_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic      clk,
   input  logic      rst,
   ccr_ctx_if.slave  bus
);

   logic [NFLAGS-1:0] ccr_q;
   logic [NFLAGS-1:0] ccr_d;
   logic              ovf_q;
   logic              ovf_d;
   logic              unf_q;
   logic              unf_d;

   logic [NFLAGS-1:0] merged_s;
   logic [NFLAGS-1:0] lifo_top_s;
   logic [CW-1:0]     lifo_cnt_s;
   logic              lifo_full_s;
   logic              lifo_empty_s;
   logic              do_push_s;
   logic              do_pop_s;
   logic              ovf_ev_s;
   logic              unf_ev_s;

   assign merged_s = NFLAGS'(ccr_merge(ccr_word_t'(ccr_q),
                                       ccr_word_t'(bus.flag_we),
                                       ccr_word_t'(bus.flag_in),
                                       ccr_word_t'(bus.set_mask),
                                       ccr_word_t'(bus.clr_mask)));

   // A simultaneous save is dropped whenever restore is requested.
   assign do_push_s = bus.save & ~bus.restore;

   // The stack snapshots the CCR as it was before this cycle's update.
   ccr_lifo #(
      .W     (NFLAGS),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk   (clk),
      .rst   (rst),
      .push  (do_push_s),
      .pop   (bus.restore),
      .din   (ccr_q),
      .dout  (lifo_top_s),
      .cnt   (lifo_cnt_s),
      .full  (lifo_full_s),
      .empty (lifo_empty_s)
   );

   // CCR source selection and sticky error next-state.
   always_comb begin
      do_pop_s = bus.restore & ~lifo_empty_s;
      ovf_ev_s = do_push_s & lifo_full_s;
      unf_ev_s = bus.restore & lifo_empty_s;

      // A successful restore overrides all live-update controls.
      if (do_pop_s) begin
         ccr_d = lifo_top_s;
      end else begin
         ccr_d = merged_s;
      end

      if (ovf_ev_s) begin
         ovf_d = 1'b1;
      end else if (bus.err_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (unf_ev_s) begin
         unf_d = 1'b1;
      end else if (bus.err_clr) begin
         unf_d = 1'b0;
      end else begin
         unf_d = unf_q;
      end
   end

   // CCR and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ccr_q <= {NFLAGS{1'b0}};
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ccr_q <= ccr_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.ccr_out     = ccr_q;
   assign bus.depth       = lifo_cnt_s;
   assign bus.stack_full  = lifo_full_s;
   assign bus.stack_empty = lifo_empty_s;
   assign bus.ovf_err     = ovf_q;
   assign bus.unf_err     = unf_q;

endmodule

// File: tb/tb_ccr_ctx.sv
module tb_ccr_ctx;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ccr_ctx_if #(.NFLAGS(4), .DEPTH(2)) ia ();
   ccr_ctx_if #(.NFLAGS(6), .DEPTH(4)) ib ();

   ccr_ctx #(.NFLAGS(4), .DEPTH(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   ccr_ctx #(.NFLAGS(6), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      ia.flag_in = 4'h0; ia.flag_we = 4'h0; ia.set_mask = 4'h0; ia.clr_mask = 4'h0;
      ia.save = 1'b0; ia.restore = 1'b0; ia.err_clr = 1'b0;
   endtask

   task automatic idle_b();
      ib.flag_in = 6'h0; ib.flag_we = 6'h0; ib.set_mask = 6'h0; ib.clr_mask = 6'h0;
      ib.save = 1'b0; ib.restore = 1'b0; ib.err_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_a(); idle_b();
      rst = 1'b1; step(); step(); rst = 1'b0;
      total++; if (ia.ccr_out !== 4'h0) begin bad++; $display("FAIL rst_ccr got=%h exp=0", ia.ccr_out); end
      total++; if (ia.depth !== 2'd0) begin bad++; $display("FAIL rst_depth got=%0d exp=0", ia.depth); end
      total++; if (ia.stack_empty !== 1'b1 || ia.stack_full !== 1'b0) begin bad++; $display("FAIL rst_status empty=%b full=%b exp 1/0", ia.stack_empty, ia.stack_full); end
      total++; if (ia.ovf_err !== 1'b0 || ia.unf_err !== 1'b0) begin bad++; $display("FAIL rst_err ovf=%b unf=%b exp 0/0", ia.ovf_err, ia.unf_err); end
      total++; if (ib.ccr_out !== 6'h0 || ib.depth !== 3'd0) begin bad++; $display("FAIL rst_wide ccr=%h depth=%0d exp 0/0", ib.ccr_out, ib.depth); end
   endtask

   task automatic test_merge();
      ia.flag_in = 4'hF; ia.flag_we = 4'b0101; step(); idle_a();
      total++; if (ia.ccr_out !== 4'b0101) begin bad++; $display("FAIL merge_we got=%b exp=0101", ia.ccr_out); end
      ia.set_mask = 4'b1000; ia.clr_mask = 4'b1001; step(); idle_a();
      total++; if (ia.ccr_out !== 4'b0100) begin bad++; $display("FAIL merge_setclr got=%b exp=0100", ia.ccr_out); end
   endtask

   task automatic test_save_restore();
      ia.flag_in = 4'h3; ia.flag_we = 4'hF; step();
      ia.flag_in = 4'hC; ia.save = 1'b1; step(); idle_a();
      total++; if (ia.ccr_out !== 4'hC || ia.depth !== 2'd1) begin bad++; $display("FAIL save ccr=%h depth=%0d exp C/1", ia.ccr_out, ia.depth); end
      ia.restore = 1'b1; step(); idle_a();
      total++; if (ia.ccr_out !== 4'h3 || ia.depth !== 2'd0 || ia.stack_empty !== 1'b1) begin bad++; $display("FAIL restore ccr=%h depth=%0d empty=%b exp 3/0/1", ia.ccr_out, ia.depth, ia.stack_empty); end
   endtask

   task automatic test_back_to_back();
      ia.flag_in = 4'h1; ia.flag_we = 4'hF; step();
      ia.save = 1'b1; ia.flag_in = 4'h2; step();
      total++; if (ia.depth !== 2'd1) begin bad++; $display("FAIL b2b_d1 got=%0d exp=1", ia.depth); end
      ia.flag_in = 4'h5; step();
      total++; if (ia.depth !== 2'd2 || ia.stack_full !== 1'b1 || ia.ovf_err !== 1'b0) begin bad++; $display("FAIL b2b_full depth=%0d full=%b ovf=%b exp 2/1/0", ia.depth, ia.stack_full, ia.ovf_err); end
      ia.flag_in = 4'h7; step(); idle_a();
      total++; if (ia.depth !== 2'd2 || ia.ovf_err !== 1'b1 || ia.ccr_out !== 4'h7) begin bad++; $display("FAIL ovf depth=%0d ovf=%b ccr=%h exp 2/1/7", ia.depth, ia.ovf_err, ia.ccr_out); end
      ia.restore = 1'b1; ia.set_mask = 4'hF; step(); idle_a();
      total++; if (ia.ccr_out !== 4'h2 || ia.depth !== 2'd1) begin bad++; $display("FAIL pop1 ccr=%h depth=%0d exp 2/1", ia.ccr_out, ia.depth); end
      ia.restore = 1'b1; step(); idle_a();
      total++; if (ia.ccr_out !== 4'h1 || ia.depth !== 2'd0) begin bad++; $display("FAIL pop2 ccr=%h depth=%0d exp 1/0", ia.ccr_out, ia.depth); end
      ia.err_clr = 1'b1; step(); idle_a();
      total++; if (ia.ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ia.ovf_err); end
   endtask

   task automatic test_underflow();
      ia.clr_mask = 4'hF; step();
      ia.clr_mask = 4'h0; ia.restore = 1'b1; ia.flag_we = 4'h1; ia.flag_in = 4'h1; step(); idle_a();
      total++; if (ia.unf_err !== 1'b1 || ia.ccr_out !== 4'h1 || ia.depth !== 2'd0) begin bad++; $display("FAIL unf unf=%b ccr=%h depth=%0d exp 1/1/0", ia.unf_err, ia.ccr_out, ia.depth); end
      ia.err_clr = 1'b1; ia.restore = 1'b1; step(); idle_a();
      total++; if (ia.unf_err !== 1'b1) begin bad++; $display("FAIL unf_clr_race got=%b exp=1", ia.unf_err); end
      ia.err_clr = 1'b1; step(); idle_a();
      total++; if (ia.unf_err !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", ia.unf_err); end
   endtask

   task automatic test_save_restore_same();
      ia.flag_in = 4'hA; ia.flag_we = 4'hF; step(); idle_a();
      ia.save = 1'b1; ia.clr_mask = 4'hF; step(); idle_a();
      total++; if (ia.ccr_out !== 4'h0 || ia.depth !== 2'd1) begin bad++; $display("FAIL same_setup ccr=%h depth=%0d exp 0/1", ia.ccr_out, ia.depth); end
      ia.save = 1'b1; ia.restore = 1'b1; step(); idle_a();
      total++; if (ia.ccr_out !== 4'hA || ia.depth !== 2'd0 || ia.ovf_err !== 1'b0 || ia.unf_err !== 1'b0) begin bad++; $display("FAIL same ccr=%h depth=%0d ovf=%b unf=%b exp A/0/0/0", ia.ccr_out, ia.depth, ia.ovf_err, ia.unf_err); end
   endtask

   task automatic test_wide_merge();
      ib.flag_in = 6'h3F; ib.flag_we = 6'b010101; step(); idle_b();
      total++; if (ib.ccr_out !== 6'b010101) begin bad++; $display("FAIL w_merge_we got=%b exp=010101", ib.ccr_out); end
      ib.set_mask = 6'b101000; ib.clr_mask = 6'b001001; step(); idle_b();
      total++; if (ib.ccr_out !== 6'b110100) begin bad++; $display("FAIL w_merge_setclr got=%b exp=110100", ib.ccr_out); end
   endtask

   task automatic test_wide_save();
      ib.flag_in = 6'h23; ib.flag_we = 6'h3F; step();
      ib.flag_in = 6'h1C; ib.save = 1'b1; step(); idle_b();
      total++; if (ib.ccr_out !== 6'h1C || ib.depth !== 3'd1) begin bad++; $display("FAIL w_save ccr=%h depth=%0d exp 1C/1", ib.ccr_out, ib.depth); end
      ib.restore = 1'b1; step(); idle_b();
      total++; if (ib.ccr_out !== 6'h23 || ib.depth !== 3'd0 || ib.stack_empty !== 1'b1) begin bad++; $display("FAIL w_restore ccr=%h depth=%0d exp 23/0", ib.ccr_out, ib.depth); end
   endtask

   task automatic test_wide_full();
      ib.flag_in = 6'h1; ib.flag_we = 6'h3F; step();
      ib.save = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         ib.flag_in = 6'(k); step();
      end
      total++; if (ib.depth !== 3'd4 || ib.stack_full !== 1'b1 || ib.ovf_err !== 1'b0 || ib.ccr_out !== 6'h5) begin bad++; $display("FAIL w_full depth=%0d full=%b ovf=%b ccr=%h exp 4/1/0/5", ib.depth, ib.stack_full, ib.ovf_err, ib.ccr_out); end
      ib.flag_in = 6'h6; step(); idle_b();
      total++; if (ib.depth !== 3'd4 || ib.ovf_err !== 1'b1 || ib.ccr_out !== 6'h6) begin bad++; $display("FAIL w_ovf depth=%0d ovf=%b ccr=%h exp 4/1/6", ib.depth, ib.ovf_err, ib.ccr_out); end
      for (int k = 0; k < 4; k++) begin
         ib.restore = 1'b1; step(); idle_b();
         total++; if (ib.ccr_out !== 6'(4 - k) || ib.depth !== 3'(3 - k)) begin bad++; $display("FAIL w_pop%0d ccr=%h depth=%0d exp %h/%0d", k, ib.ccr_out, ib.depth, 4 - k, 3 - k); end
      end
   endtask

   task automatic test_reset_midseq();
      ia.restore = 1'b1; step(); idle_a();
      ia.flag_in = 4'h9; ia.flag_we = 4'hF; ia.save = 1'b1; step(); step(); step(); idle_a();
      total++; if (ia.depth !== 2'd2 || ia.ovf_err !== 1'b1 || ia.unf_err !== 1'b1) begin bad++; $display("FAIL mid_setup depth=%0d ovf=%b unf=%b exp 2/1/1", ia.depth, ia.ovf_err, ia.unf_err); end
      rst = 1'b1; ia.save = 1'b1; ia.flag_in = 4'hF; ia.flag_we = 4'hF; step(); rst = 1'b0; idle_a();
      total++; if (ia.depth !== 2'd0 || ia.ccr_out !== 4'h0 || ia.stack_empty !== 1'b1) begin bad++; $display("FAIL mid_rst depth=%0d ccr=%h empty=%b exp 0/0/1", ia.depth, ia.ccr_out, ia.stack_empty); end
      total++; if (ia.ovf_err !== 1'b0 || ia.unf_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err ovf=%b unf=%b exp 0/0", ia.ovf_err, ia.unf_err); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_a();
      idle_b();
      test_reset();
      test_merge();
      test_save_restore();
      test_back_to_back();
      test_underflow();
      test_save_restore_same();
      test_wide_merge();
      test_wide_save();
      test_wide_full();
      test_reset_midseq();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
